// File: rtl/contador_monitor_pkg.sv
// Shared types for the cascaded-counter monitor: event kinds and the FIFO entry format.
package contador_monitor_pkg;

  localparam logic KIND_LOAD = 1'b0;
  localparam logic KIND_RCO  = 1'b1;

  typedef struct packed {
    logic        kind;
    logic [31:0] data;
  } evt_t;

endpackage

// File: rtl/evt_fifo.sv
// Show-ahead event FIFO: the head entry is visible combinationally whenever not empty.
module evt_fifo
  import contador_monitor_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  evt_t                     push_data,
  input  logic                     pop,
  output evt_t                     head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  evt_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // A push into a full FIFO is legal when the same edge frees the head slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: storage has no reset; only the pointers define validity, which keeps the array as plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (level == FULL_LEVEL);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/contador_monitor.sv
// Watches the cascaded counter's rco/load/Q, turns rising edges into tagged events and queues them.
module contador_monitor
  import contador_monitor_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WRAP_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rco_in,
  input  logic                   load_in,
  input  logic [31:0]            q_in,
  input  logic                   evt_ready,
  input  logic                   clr_ovf,
  output logic                   evt_valid,
  output logic                   evt_kind,
  output logic [31:0]            evt_data,
  output logic [WRAP_W-1:0]      wrap_cnt,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf
);

  logic              s_rco, s_load, p_rco, p_load;
  logic [31:0]       s_q;
  logic              rise_rco, rise_load;
  logic [WRAP_W-1:0] wrap_next;
  logic              pend_valid;
  logic [31:0]       pend_data;
  logic              set_pend;
  logic              push_req;
  evt_t              push_evt;
  evt_t              head;
  logic              full, empty, pop, drop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_rco  <= 1'b0;
      s_load <= 1'b0;
      s_q    <= '0;
      p_rco  <= 1'b0;
      p_load <= 1'b0;
    end else begin
      s_rco  <= rco_in;
      s_load <= load_in;
      s_q    <= q_in;
      p_rco  <= s_rco;
      p_load <= s_load;
    end
  end

  assign rise_rco  = s_rco & ~p_rco;
  assign rise_load = s_load & ~p_load;
  assign wrap_next = wrap_cnt + WRAP_W'(1);

  // Simultaneous rises: LOAD goes now, RCO waits one cycle in the pending slot.
  assign set_pend = rise_load & rise_rco & ~pend_valid;

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    push_req = 1'b0;
    push_evt = '0;
    if (pend_valid) begin
      push_req = 1'b1;
      push_evt = '{kind: KIND_RCO, data: pend_data};
    end else if (rise_load) begin
      push_req = 1'b1;
      push_evt = '{kind: KIND_LOAD, data: s_q};
    end else if (rise_rco) begin
      push_req = 1'b1;
      push_evt = '{kind: KIND_RCO, data: 32'(wrap_next)};
    end
  end

  assign evt_valid = ~empty;
  assign pop       = evt_valid & evt_ready;
  assign drop      = push_req & full & ~pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrap_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      ovf        <= 1'b0;
    end else begin
      if (rise_rco) wrap_cnt <= wrap_next;
      pend_valid <= set_pend;
      if (set_pend) pend_data <= 32'(wrap_next);
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req),
    .push_data (push_evt),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign evt_kind = evt_valid ? head.kind : KIND_LOAD;
  assign evt_data = evt_valid ? head.data : '0;

endmodule

// File: tb/tb_contador_monitor.sv
// Directed and random stimulus against a queue-based event model of the counter monitor.
module tb_contador_monitor;
  import contador_monitor_pkg::*;

  localparam int DEPTH  = 4;
  localparam int WRAP_W = 8;
  localparam int WMOD   = 2 ** WRAP_W;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              rco_in, load_in, evt_ready, clr_ovf;
  logic [31:0]       q_in;
  logic              evt_valid, evt_kind, ovf;
  logic [31:0]       evt_data;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [LW-1:0]     level;

  int checks = 0;
  int errors = 0;

  // Reference model: input history, wrap count, pending RCO, event queue {kind, data}.
  bit          ms_rco, ms_load, mp_rco, mp_load;
  logic [31:0] ms_q;
  bit          mpend;
  logic [31:0] mpend_data;
  int          mwrap;
  bit          movf;
  logic [32:0] mq[$];

  contador_monitor #(.DEPTH(DEPTH), .WRAP_W(WRAP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .rco_in    (rco_in),
    .load_in   (load_in),
    .q_in      (q_in),
    .evt_ready (evt_ready),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_kind  (evt_kind),
    .evt_data  (evt_data),
    .wrap_cnt  (wrap_cnt),
    .level     (level),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [32:0] hd;
    hd = (mq.size() > 0) ? mq[0] : 33'd0;
    check({tag, ".valid"}, {31'd0, evt_valid}, {31'd0, mq.size() > 0});
    check({tag, ".kind"},  {31'd0, evt_kind},  {31'd0, hd[32]});
    check({tag, ".data"},  evt_data,           hd[31:0]);
    check({tag, ".level"}, 32'(level),         32'(mq.size()));
    check({tag, ".wrap"},  32'(wrap_cnt),      32'(mwrap));
    check({tag, ".ovf"},   {31'd0, ovf},       {31'd0, movf});
  endtask

  task automatic model_reset();
    ms_rco = 0; ms_load = 0; mp_rco = 0; mp_load = 0; ms_q = '0;
    mpend = 0; mpend_data = '0; mwrap = 0; movf = 0;
    mq.delete();
  endtask

  // One clock: drive inputs, advance the model by the spec's event rules, compare after the edge.
  task automatic tick(input bit r, input bit l, input logic [31:0] q, input bit rdy, input bit clr);
    bit          rr, rl, pop, have, drop, was_full;
    logic [32:0] ev;
    rco_in = r; load_in = l; q_in = q; evt_ready = rdy; clr_ovf = clr;
    rr = ms_rco && !mp_rco;
    rl = ms_load && !mp_load;
    pop = (mq.size() > 0) && rdy;
    was_full = (mq.size() == DEPTH);
    have = 0; drop = 0; ev = '0;
    if (mpend) begin
      have = 1; ev = {1'b1, mpend_data}; mpend = 0;
    end else if (rl) begin
      have = 1; ev = {1'b0, ms_q};
      if (rr) begin mpend = 1; mpend_data = 32'((mwrap + 1) % WMOD); end
    end else if (rr) begin
      have = 1; ev = {1'b1, 32'((mwrap + 1) % WMOD)};
    end
    if (rr) mwrap = (mwrap + 1) % WMOD;
    if (pop) void'(mq.pop_front());
    if (have) begin
      if (!was_full || pop) mq.push_back(ev);
      else drop = 1;
    end
    if (drop) movf = 1;
    else if (clr) movf = 0;
    mp_rco = ms_rco; mp_load = ms_load;
    ms_rco = r; ms_load = l; ms_q = q;
    @(posedge clk);
    #1;
    compare_all("cyc");
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; rco_in = 0; load_in = 0; q_in = '0; evt_ready = 0; clr_ovf = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    compare_all("reset");
    repeat (2) tick(0, 0, 32'd0, 0, 0);

    // rco held high through reset release -> single RCO event with data 1
    reset = 1'b0;
    rco_in = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    tick(1, 0, 32'd0, 0, 0);
    tick(1, 0, 32'd0, 0, 0);
    check("rco_release.data", evt_data, 32'd1);
    repeat (3) tick(1, 0, 32'd0, 0, 0);
    check("rco_release.level", 32'(level), 32'd1);
    repeat (2) tick(0, 0, 32'd0, 1, 0);

    // single load pulse, visible two edges after the sample
    tick(0, 1, 32'h0000_00A5, 1, 0);
    check("load.not_yet", {31'd0, evt_valid}, 32'd0);
    tick(0, 0, 32'd0, 1, 0);
    check("load.data", evt_data, 32'h0000_00A5);
    repeat (2) tick(0, 0, 32'd0, 1, 0);

    // rco and load rise together: LOAD first, RCO one cycle later
    do_reset();
    tick(1, 1, 32'h1234_5678, 0, 0);
    tick(1, 1, 32'h1234_5678, 0, 0);
    check("both.first", evt_data, 32'h1234_5678);
    tick(0, 0, 32'd0, 0, 0);
    check("both.level", 32'(level), 32'd2);
    check("both.wrap", 32'(wrap_cnt), 32'd1);
    repeat (3) tick(0, 0, 32'd0, 1, 0);

    // overflow with ready low, then clear
    for (int i = 0; i < 5; i++) begin
      tick(0, 1, 32'h100 + 32'(i), 0, 0);
      tick(0, 0, 32'd0, 0, 0);
    end
    tick(0, 0, 32'd0, 0, 0);
    check("ovf.level", 32'(level), 32'(DEPTH));
    check("ovf.flag", {31'd0, ovf}, 32'd1);
    tick(0, 0, 32'd0, 0, 1);
    check("ovf.clear", {31'd0, ovf}, 32'd0);
    repeat (5) tick(0, 0, 32'd0, 1, 0);

    // wrap counter rollover
    do_reset();
    for (int i = 0; i < WMOD - 1; i++) begin
      tick(1, 0, 32'd0, 1, 0);
      tick(0, 0, 32'd0, 1, 0);
    end
    check("wrap.max", 32'(wrap_cnt), 32'(WMOD - 1));
    tick(1, 0, 32'd0, 1, 0);
    tick(0, 0, 32'd0, 1, 0);
    check("wrap.zero", 32'(wrap_cnt), 32'd0);
    check("wrap.evt_kind", {31'd0, evt_kind}, 32'd1);
    check("wrap.evt_data", evt_data, 32'd0);
    repeat (2) tick(0, 0, 32'd0, 1, 0);

    // asynchronous reset while holding three entries
    for (int i = 0; i < 3; i++) begin
      tick(0, 1, 32'hC0 + 32'(i), 0, 0);
      tick(0, 0, 32'd0, 0, 0);
    end
    tick(0, 0, 32'd0, 0, 0);
    check("midrst.before", 32'(level), 32'd3);
    reset = 1'b0;
    #1;
    check("midrst.level", 32'(level), 32'd0);
    check("midrst.valid", {31'd0, evt_valid}, 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    tick(0, 0, 32'd0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/contador_monitor.md
# contador_monitor

Downstream consumer of the 32-bit cascaded counter. Samples the counter's `rco`, `load` and `Q` outputs, turns rising edges of `rco` and `load` into tagged events, and buffers them in a small FIFO. A valid/ready port presents the events to the next stage, the register/bus interface. It also keeps a running wrap count and a sticky overflow flag.

## Interface
- `DEPTH`, 4, event FIFO depth; power of two, ≥2
- `WRAP_W`, 16, width of the wrap (rco-edge) counter; ≤32
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `rco_in`  in  1  counter `rco` output
- `load_in`  in  1  counter `load` output
- `q_in`  in  32  counter `Q` output
- `evt_ready`  in  1  consumer ready
- `clr_ovf`  in  1  synchronous clear of `ovf`
- `evt_valid`  out  1  FIFO head valid
- `evt_kind`  out  1  0 = LOAD event, 1 = RCO event
- `evt_data`  out  32  LOAD: captured `q_in`; RCO: wrap count after increment, zero-extended
- `wrap_cnt`  out  WRAP_W  number of rco rising edges seen, modulo 2^WRAP_W
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy
- `ovf`  out  1  sticky flag: an event was dropped

## Operation
- Input stage: `rco_in`, `load_in` and `q_in` are registered together into `s_rco`, `s_load` and `s_q`.
- Edge-detect stage: the previous `s_rco` and `s_load` are held in `p_rco` and `p_load`.
  - rise_rco = s_rco & ~p_rco
  - rise_load = s_load & ~p_load
- All sample and previous flops reset to 0. An input that is high when reset is released therefore produces one edge.
- rise_load pushes {LOAD, s_q}.
- rise_rco increments `wrap_cnt`, wrapping to 0 after all-ones, and pushes {RCO, new wrap_cnt}.
- Both rises in the same cycle:
  - LOAD is pushed that cycle.
  - RCO is latched in a one-entry pending slot and pushed the following cycle.
  - `wrap_cnt` increments in the cycle of the edge.
  - The pending slot takes priority over a new rise. A new rise of the same signal cannot occur in that next cycle.
- FIFO behaviour:
  - Show-ahead: `evt_kind` and `evt_data` are the head entry whenever `evt_valid`=1.
  - Pop when `evt_valid & evt_ready`.
  - A push while full is accepted only if a pop happens in the same cycle.
  - Otherwise the event is dropped and `ovf` is set. This includes a pending RCO that finds the FIFO full.
- `ovf` is cleared by `clr_ovf`=1. A drop in the same cycle as `clr_ovf` wins, so `ovf` stays 1.
- Outputs while `evt_valid`=0: `evt_data` and `evt_kind` are 0.

## Timing
- Reset values: `evt_valid`=0, `evt_kind`=0, `evt_data`=0, `wrap_cnt`=0, `level`=0, `ovf`=0. The pending slot is empty.
- Reset is asynchronous. Asserting it mid-operation discards FIFO contents and the pending event immediately.
- Latency: an input first sampled high at edge k is detected in cycle k→k+1 and written at edge k+1.
  - `evt_valid` rises after edge k+1 if the FIFO was empty.
  - This gives two edges from input to visible event.
  - A pending RCO appears one edge later.
- `wrap_cnt` updates at edge k+1.
- Inputs are assumed stable around `clk`; no synchronizer is added. The counter shares `clk`.
- `evt_data` holds stable while `evt_valid`=1 and `evt_ready`=0.

## Structure
- Package `contador_monitor_pkg` holds:
  - `KIND_LOAD` = 1'b0 and `KIND_RCO` = 1'b1
  - an `evt_t` struct {kind, data[31:0]}
- Sub-module `evt_fifo` (DEPTH, show-ahead, push/pop/full/empty/level) contains the storage and pointers.
- The top level holds the sample/edge registers, `wrap_cnt`, the pending slot and `ovf`.

## Test plan
- Reset with all inputs 0, then release → all outputs 0. Hold `rco_in`=1 through release → one RCO event with data 1.
- `q_in`=0x0000_00A5 with a `load_in` pulse, `evt_ready`=1 → one LOAD event, data 0xA5, `evt_valid` two edges after the sample.
- `rco_in` and `load_in` rise together, `q_in`=0x1234_5678 → LOAD 0x12345678 first, then RCO 1 on the next cycle, `wrap_cnt`=1.
- `evt_ready`=0, DEPTH=4, 5 separated load pulses → `level`=4, `ovf`=1, first 4 data preserved. Then `clr_ovf` → `ovf`=0.
- `wrap_cnt` preset to 0xFFFF by 65535 edges, then one more rco edge → `wrap_cnt`=0, event data 0x0000_0000.
- Assert reset while the FIFO holds 3 entries → `level`=0 and `evt_valid`=0 immediately, with no clock edge needed.
